// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access codes
// and the wait-state FSM encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsuState_t;

endpackage

// File: rtl/lsu_byte_mem.sv
// Word-organised data memory with per-byte write enables, synchronous write
// and combinational read. Contents are deliberately not reset.
module lsu_byte_mem
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [XLEN/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Only the enabled byte lanes of the addressed word are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < XLEN/8; b++) begin
            if (we && be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM stage of the five-stage RISC-V pipeline: sub-word loads/stores,
// misalign detection, wait-state stalling and the M->W pipeline register.
module memory_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int LAT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            regwrite_m,
    input  logic            resultsrc_m,
    input  logic            memread_m,
    input  logic            memwrite_m,
    input  logic [2:0]      funct3_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] aluresult_m,
    input  logic [XLEN-1:0] writedata_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic            regwrite_w,
    output logic            resultsrc_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] aluresult_w,
    output logic [XLEN-1:0] readdata_w,
    output logic            misalign_w
);

    localparam int         AW       = $clog2(DEPTH);
    localparam bit         HAS_WAIT = (LAT > 0);
    localparam logic [2:0] LAT_M1   = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    lsuState_t       state, stateNext;
    logic [2:0]      cnt, cntNext;
    logic [1:0]      byteOff;
    logic [AW-1:0]   wordIdx;
    logic            isHalfAcc, isWordAcc, isByteAcc;
    logic            misalign, memOp, alignedOp, isLoad, memWe;
    logic [3:0]      byteEn;
    logic [XLEN-1:0] storeData, memWord, loadData, readNext;
    logic [7:0]      laneByte;
    logic [15:0]     laneHalf;
    logic            unusedAddrBits;

    assign byteOff        = aluresult_m[1:0];
    assign wordIdx        = aluresult_m[AW+1:2];
    assign unusedAddrBits = ^aluresult_m[XLEN-1:AW+2];

    // Codes 011/110/111 have funct3[1] set and so fall into the word case.
    assign isByteAcc = (funct3_m[1:0] == 2'b00);
    assign isHalfAcc = (funct3_m[1:0] == 2'b01);
    assign isWordAcc = funct3_m[1];
    assign misalign  = (isHalfAcc & byteOff[0]) | (isWordAcc & (byteOff != 2'b00));

    assign memOp     = valid_m & (memread_m | memwrite_m);
    assign alignedOp = memOp & ~misalign;
    assign isLoad    = memread_m & ~memwrite_m;
    assign memWe     = alignedOp & memwrite_m & ~stall_m;

    always_comb begin
        byteEn    = 4'b1111;
        storeData = writedata_m;
        if (isByteAcc) begin
            byteEn    = 4'b0001 << byteOff;
            storeData = {4{writedata_m[7:0]}};
        end else if (isHalfAcc) begin
            byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
            storeData = {2{writedata_m[15:0]}};
        end
    end

    lsu_byte_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) uMem (
        .clk   (clk),
        .we    (memWe),
        .be    (byteEn),
        .addr  (wordIdx),
        .wdata (storeData),
        .rdata (memWord)
    );

    assign laneByte = memWord[{byteOff, 3'b000} +: 8];
    assign laneHalf = byteOff[1] ? memWord[31:16] : memWord[15:0];

    // funct3[2] selects zero extension (LBU/LHU) over sign extension.
    always_comb begin
        loadData = memWord;
        if (isByteAcc) begin
            loadData = {{(XLEN-8){laneByte[7] & ~funct3_m[2]}}, laneByte};
        end else if (isHalfAcc) begin
            loadData = {{(XLEN-16){laneHalf[15] & ~funct3_m[2]}}, laneHalf};
        end
    end

    assign readNext = (alignedOp && isLoad) ? loadData : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (alignedOp && HAS_WAIT) begin
                    cntNext   = LAT_M1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) cntNext = cnt - 3'd1;
                else             stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The final WAIT cycle releases the stall so the completing edge is also
    // the edge that writes memory and loads the W register.
    always_comb begin
        stall_m = 1'b0;
        case (state)
            IDLE:    stall_m = alignedOp && HAS_WAIT;
            WAIT:    stall_m = (cnt != 3'd0);
            default: stall_m = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall_m) begin
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            resultsrc_w <= 1'b0;
            rd_w        <= 5'd0;
            aluresult_w <= '0;
            readdata_w  <= '0;
            misalign_w  <= 1'b0;
        end else begin
            valid_w     <= valid_m;
            regwrite_w  <= valid_m & regwrite_m & ~(memOp & misalign);
            resultsrc_w <= resultsrc_m;
            rd_w        <= rd_m;
            aluresult_w <= aluresult_m;
            readdata_w  <= readNext;
            misalign_w  <= memOp & misalign;
        end
    end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu: one zero-latency and one three-wait-state
// instance share stimulus, each enabled by its own valid.
module tb_memory_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid0, valid3, regwrite, resultsrc, memread, memwrite;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] aluresult, writedata;

    logic        stall0, vw0, rw0, rs0, mis0;
    logic [4:0]  rdw0;
    logic [31:0] aluw0, rdata0;
    logic        stall3, vw3, rw3, rs3, mis3;
    logic [4:0]  rdw3;
    logic [31:0] aluw3, rdata3;

    int vectorCount    = 0;
    int miscompareCount = 0;

    always #5 clk = ~clk;

    memory_stage_lsu #(.XLEN(32), .DEPTH(1024), .LAT(0)) uLat0 (
        .clk(clk), .rst(rst), .valid_m(valid0), .regwrite_m(regwrite),
        .resultsrc_m(resultsrc), .memread_m(memread), .memwrite_m(memwrite),
        .funct3_m(funct3), .rd_m(rd), .aluresult_m(aluresult), .writedata_m(writedata),
        .stall_m(stall0), .valid_w(vw0), .regwrite_w(rw0), .resultsrc_w(rs0),
        .rd_w(rdw0), .aluresult_w(aluw0), .readdata_w(rdata0), .misalign_w(mis0)
    );

    memory_stage_lsu #(.XLEN(32), .DEPTH(1024), .LAT(3)) uLat3 (
        .clk(clk), .rst(rst), .valid_m(valid3), .regwrite_m(regwrite),
        .resultsrc_m(resultsrc), .memread_m(memread), .memwrite_m(memwrite),
        .funct3_m(funct3), .rd_m(rd), .aluresult_m(aluresult), .writedata_m(writedata),
        .stall_m(stall3), .valid_w(vw3), .regwrite_w(rw3), .resultsrc_w(rs3),
        .rd_w(rdw3), .aluresult_w(aluw3), .readdata_w(rdata3), .misalign_w(mis3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic v3, input logic rw, input logic rsrc,
                                 input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [4:0] rdx, input logic [31:0] addr, input logic [31:0] wd);
        valid0    = v0;
        valid3    = v3;
        regwrite  = rw;
        resultsrc = rsrc;
        memread   = mr;
        memwrite  = mw;
        funct3    = f3;
        rd        = rdx;
        aluresult = addr;
        writedata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store0(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        applyStimulus(1, 0, 0, 0, 0, 1, f3, 5'd0, addr, wd);
        tick();
    endtask

    task automatic load0(input logic [2:0] f3, input logic [31:0] addr);
        applyStimulus(1, 0, 1, 1, 1, 0, f3, 5'd5, addr, 32'h0);
        tick();
    endtask

    // Holds a LAT=3 op until the stall drops, then takes the capture edge.
    task automatic issue3(input string tag);
        int stallCycles = 0;
        #1;
        while (stall3 && stallCycles < 20) begin
            tick();
            stallCycles++;
        end
        checkOutput(tag, 32'(stallCycles), 32'd3);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst valid_w", {31'd0, vw0}, 32'd0);
        checkOutput("rst readdata_w", rdata3, 32'd0);
        checkOutput("rst stall_m", {30'd0, stall0, stall3}, 32'd0);
        rst = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 1, 3'b010, 5'd0, 32'h10, 32'hDEADBEEF);
        #1;
        checkOutput("lat0 sw stall", {31'd0, stall0}, 32'd0);
        tick();
        load0(3'b010, 32'h10);
        checkOutput("lw 0x10", rdata0, 32'hDEADBEEF);
        checkOutput("lw ctrl", {26'd0, vw0, rw0, rs0, rdw0[2:0]}, {26'd0, 3'b111, 3'd5});
        load0(3'b000, 32'h13);
        checkOutput("lb 0x13", rdata0, 32'hFFFFFFDE);
        load0(3'b100, 32'h13);
        checkOutput("lbu 0x13", rdata0, 32'h000000DE);
        load0(3'b001, 32'h12);
        checkOutput("lh 0x12", rdata0, 32'hFFFFDEAD);

        store0(3'b010, 32'h20, 32'hAAAAAAAA);
        store0(3'b001, 32'h22, 32'hFFFF1234);
        load0(3'b010, 32'h20);
        checkOutput("sh merge", rdata0, 32'h1234AAAA);
        load0(3'b001, 32'h22);
        checkOutput("lh 0x22", rdata0, 32'h00001234);
        store0(3'b000, 32'h21, 32'h99887777);
        load0(3'b010, 32'h20);
        checkOutput("sb merge", rdata0, 32'h123477AA);
        load0(3'b101, 32'h20);
        checkOutput("lhu 0x20", rdata0, 32'h000077AA);

        applyStimulus(1, 0, 1, 1, 1, 0, 3'b010, 5'd9, 32'h12, 32'h0);
        #1;
        checkOutput("misalign stall", {31'd0, stall0}, 32'd0);
        tick();
        checkOutput("misalign flags", {28'd0, vw0, rw0, mis0, 1'b0}, {28'd0, 4'b1010});
        checkOutput("misalign data", rdata0, 32'd0);
        load0(3'b001, 32'h13);
        checkOutput("lh misalign", {31'd0, mis0}, 32'd1);
        store0(3'b010, 32'h11, 32'h00000000);
        checkOutput("sw misalign", {31'd0, mis0}, 32'd1);
        load0(3'b010, 32'h10);
        checkOutput("lw after misalign", rdata0, 32'hDEADBEEF);
        checkOutput("misalign clear", {31'd0, mis0}, 32'd0);

        applyStimulus(1, 0, 1, 0, 0, 0, 3'b000, 5'd7, 32'h55, 32'h0);
        tick();
        checkOutput("add alu", aluw0, 32'h55);
        checkOutput("add data", rdata0, 32'h0);
        checkOutput("add rw", {27'd0, rw0, 4'd0}, {27'd0, 1'b1, 4'd0});

        store0(3'b010, 32'h1008, 32'hCAFEF00D);
        load0(3'b010, 32'h8);
        checkOutput("alias 0x1008", rdata0, 32'hCAFEF00D);

        applyStimulus(1, 0, 1, 1, 1, 1, 3'b010, 5'd3, 32'h30, 32'h11223344);
        tick();
        checkOutput("rd+wr data", rdata0, 32'h0);
        load0(3'b110, 32'h30);
        checkOutput("rd+wr stored", rdata0, 32'h11223344);

        applyStimulus(0, 1, 0, 0, 0, 1, 3'b010, 5'd0, 32'h40, 32'h0BADF00D);
        issue3("lat3 sw stalls");

        applyStimulus(0, 1, 1, 1, 1, 0, 3'b010, 5'd6, 32'h40, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("lat3 stall c%0d", c), {31'd0, stall3}, 32'd1);
            tick();
            checkOutput($sformatf("lat3 bubble c%0d", c), {30'd0, vw3, rw3}, 32'd0);
        end
        #1;
        checkOutput("lat3 release", {31'd0, stall3}, 32'd0);
        tick();
        checkOutput("lat3 lw data", rdata3, 32'h0BADF00D);
        checkOutput("lat3 lw ctrl", {27'd0, vw3, rdw3[3:0]}, {27'd0, 1'b1, 4'd6});
        applyStimulus(0, 1, 1, 0, 0, 0, 3'b000, 5'd8, 32'h77, 32'h0);
        #1;
        checkOutput("lat3 add stall", {31'd0, stall3}, 32'd0);
        tick();
        checkOutput("lat3 add alu", aluw3, 32'h77);
        checkOutput("lat3 add valid", {31'd0, vw3}, 32'd1);

        applyStimulus(0, 1, 0, 0, 0, 1, 3'b010, 5'd0, 32'h40, 32'h12345678);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        #1;
        checkOutput("abort outputs", {aluw3[15:0], 10'd0, vw3, rw3, rs3, mis3, stall3, 1'b0}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 1, 1, 1, 1, 0, 3'b010, 5'd6, 32'h40, 32'h0);
        issue3("post-rst lw stalls");
        checkOutput("abort no write", rdata3, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
